fft_sample_writer: RTL

- Write-side counterpart of the FFT sequence loader.
- Captures a stereo sample stream into the shared waveform dual-port RAM, one frame at a time.
- Uses the same address map as the loader: MSB selects the channel (0 = Lch, 1 = Rch); the lower bits hold the sample index.
- Writes one frame of 2^(bw_dpram-1) sample pairs, then raises FrameReady and pulses FrameDone so the loader or VRAM controller can start FFT sequencing. It re-arms only on request, so a frame is never overwritten while it is being read.

---
 rtl/fft_sample_writer_pkg.sv | 27 ++
 rtl/fft_sample_writer_if.sv | 28 ++
 rtl/fft_sample_writer_sat.sv | 21 ++
 rtl/fft_sample_writer.sv | 117 +++++++++++
 4 files changed

// File: rtl/fft_sample_writer_pkg.sv
// Shared definitions for the FFT waveform RAM writer: state encoding,
// channel-select constants (common with the sequence loader) and frame length.
package fft_sample_writer_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ARMED = 3'd1;
   localparam logic [2:0] ST_WR_L  = 3'd2;
   localparam logic [2:0] ST_WR_R  = 3'd3;
   localparam logic [2:0] ST_FULL  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      ARMED = ST_ARMED,
      WR_L  = ST_WR_L,
      WR_R  = ST_WR_R,
      FULL  = ST_FULL
   } writerState_t;

   localparam logic CH_L = 1'b0;
   localparam logic CH_R = 1'b1;

   // Address MSB is the channel select, so a frame uses half the address space.
   function automatic int frameLen(input int bwDpram);
      return 1 << (bwDpram - 1);
   endfunction

endpackage

// File: rtl/fft_sample_writer_if.sv
// Stereo sample input and DPRAM write-side bus of the FFT sample writer.
interface fft_sample_writer_if #(
   parameter int bw_dpram = 12,
   parameter int bw_data  = 16,
   parameter int bw_ovr   = 8
);
   logic                Arm;
   logic                SampleValid;
   logic [bw_data-1:0]  SampleL;
   logic [bw_data-1:0]  SampleR;
   logic [bw_dpram-1:0] WriteAddr;
   logic [bw_data-1:0]  WriteData;
   logic                WriteEn;
   logic                Busy;
   logic                FrameReady;
   logic                FrameDone;
   logic [bw_ovr-1:0]   OverrunCount;

   modport master (
      output Arm, SampleValid, SampleL, SampleR,
      input  WriteAddr, WriteData, WriteEn, Busy, FrameReady, FrameDone, OverrunCount
   );

   modport slave (
      input  Arm, SampleValid, SampleL, SampleR,
      output WriteAddr, WriteData, WriteEn, Busy, FrameReady, FrameDone, OverrunCount
   );
endinterface

// File: rtl/fft_sample_writer_sat.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Clear,
   input  logic             Inc,
   output logic [WIDTH-1:0] Count
);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)
         Count <= '0;
      else if (Clear)
         Count <= '0;
      else if (Inc && (Count != '1))
         Count <= Count + WIDTH'(1);
   end

endmodule

// File: rtl/fft_sample_writer.sv
// Captures stereo sample pairs into the waveform DPRAM one frame at a time,
// L then R per pair, and holds the frame until re-armed.
module fft_sample_writer
   import fft_sample_writer_pkg::*;
#(
   parameter int bw_dpram = 12,
   parameter int bw_data  = 16,
   parameter int bw_ovr   = 8
) (
   input logic                 Clock,
   input logic                 Reset,
   fft_sample_writer_if.slave  bus
);

   localparam int IDX_W = bw_dpram - 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(frameLen(bw_dpram) - 1);

   writerState_t        state;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idxNext;
   logic [bw_data-1:0]  holdR;
   logic [bw_dpram-1:0] writeAddr;
   logic [bw_data-1:0]  writeData;
   logic                writeEn;
   logic                busy;
   logic                frameReady;
   logic                frameDone;
   logic                ovrClear;
   logic                ovrInc;

   assign idxNext  = idx + IDX_W'(1);
   assign ovrClear = bus.Arm && ((state == IDLE) || (state == FULL));
   assign ovrInc   = bus.SampleValid && (state == WR_L);

   // The left sample goes straight into the write-data register, which serves
   // as its hold stage; only the right sample needs a separate hold register.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         idx        <= '0;
         holdR      <= '0;
         writeEn    <= 1'b0;
         writeAddr  <= '0;
         writeData  <= '0;
         busy       <= 1'b0;
         frameReady <= 1'b0;
         frameDone  <= 1'b0;
      end else begin
         writeEn   <= 1'b0;
         frameDone <= 1'b0;
         case (state)
            IDLE, FULL: begin
               if (bus.Arm) begin
                  state      <= ARMED;
                  idx        <= '0;
                  frameReady <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            ARMED: begin
               if (bus.SampleValid) begin
                  holdR     <= bus.SampleR;
                  writeEn   <= 1'b1;
                  writeAddr <= {CH_L, idx};
                  writeData <= bus.SampleL;
                  state     <= WR_L;
               end
            end
            WR_L: begin
               writeEn   <= 1'b1;
               writeAddr <= {CH_R, idx};
               writeData <= holdR;
               state     <= WR_R;
            end
            WR_R: begin
               if (idx == LAST_IDX) begin
                  idx        <= '0;
                  state      <= FULL;
                  busy       <= 1'b0;
                  frameReady <= 1'b1;
                  frameDone  <= 1'b1;
               end else begin
                  idx <= idxNext;
                  if (bus.SampleValid) begin
                     holdR     <= bus.SampleR;
                     writeEn   <= 1'b1;
                     writeAddr <= {CH_L, idxNext};
                     writeData <= bus.SampleL;
                     state     <= WR_L;
                  end else begin
                     state <= ARMED;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sat_counter #(
      .WIDTH (bw_ovr)
   ) overrunCounter (
      .Clock (Clock),
      .Reset (Reset),
      .Clear (ovrClear),
      .Inc   (ovrInc),
      .Count (bus.OverrunCount)
   );

   assign bus.WriteEn    = writeEn;
   assign bus.WriteAddr  = writeAddr;
   assign bus.WriteData  = writeData;
   assign bus.Busy       = busy;
   assign bus.FrameReady = frameReady;
   assign bus.FrameDone  = frameDone;

endmodule
